// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants for the instruction-fetch front end.
//                Holds the default address width, the default reset PC, the
//                instruction size in bytes and the instruction word width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int          c_XLEN_DEFAULT     = 32;
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          c_INST_BYTES       = 4;
    localparam int          c_INST_W           = 32;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the instruction-memory request/response channel and
//                the decode-side instruction handshake.
//  Ports       : (interface signals)
//                imem_req_valid/ready/addr : request channel, fetch -> memory
//                imem_rsp_valid/data       : in-order response, no backpressure
//                inst_valid/ready/data/pc  : queue head towards decode
//                modport master            : fetch unit side
//                modport slave             : memory + decode side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
);

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [XLEN-1:0]       imem_req_addr;
    logic                  imem_rsp_valid;
    logic [c_INST_W-1:0]   imem_rsp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [c_INST_W-1:0]   inst_data;
    logic [XLEN-1:0]       inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO holding {pc, instruction} entries for the
//                fetch front end. Flush empties it in one cycle and wins over
//                push and pop. Storage is not reset; only the head selected
//                by a non-zero count is ever observed.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                push_i/push_data_i - write one entry at the tail
//                pop_i              - drop the head entry
//                flush_i            - discard all entries
//                count_o            - number of valid entries (0..DEPTH)
//                head_o             - oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter  int DEPTH   = 4,
    parameter  int WIDTH   = 64,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               push_i,
    input  wire logic [WIDTH-1:0]   push_data_i,
    input  wire logic               pop_i,
    input  wire logic               flush_i,
    output logic      [c_CNT_W-1:0] count_o,
    output logic      [WIDTH-1:0]   head_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push_i && !flush_i;
    assign w_do_pop  = pop_i && !flush_i && (count_q != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Pipelined instruction-fetch front end. Issues word-aligned
//                requests under a credit limit so every response fits in the
//                prefetch queue, tags responses with a return PC, and on a
//                redirect flushes the queue and marks all in-flight responses
//                as stale.
//  Ports       : clk, reset   - clock, asynchronous active-high reset
//                jump_flag    - single-cycle redirect request
//                jump_target  - redirect address (bits [1:0] ignored)
//                bus (master) - imem request/response and decode handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = c_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC_DEFAULT),
    parameter int              DEPTH    = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            jump_flag,
    input  wire logic [XLEN-1:0] jump_target,
    fetch_unit_if.master         bus
);

    localparam int                c_CNT_W     = cnt_width(DEPTH);
    localparam int                c_ENT_W     = XLEN + c_INST_W;
    localparam logic [XLEN-1:0]   c_PC_STEP   = XLEN'(c_INST_BYTES);
    localparam logic [c_CNT_W:0]  c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    ret_pc_q,   ret_pc_d;
    logic [c_CNT_W-1:0] out_q,      out_d;
    logic [c_CNT_W-1:0] disc_q,     disc_d;

    logic [c_CNT_W-1:0] w_count;
    logic [c_ENT_W-1:0] w_head;
    logic [XLEN-1:0]    w_target;
    logic               w_credit;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_inst_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_tgt;

    assign w_target     = {jump_target[XLEN-1:2], 2'b00};
    assign w_unused_tgt = ^jump_target[1:0];

    // Outstanding requests plus queued entries may never exceed DEPTH, so a
    // response always has a free slot and memory never needs backpressure.
    assign w_credit     = ({1'b0, out_q} + {1'b0, w_count}) < c_DEPTH_EXT;
    assign w_req_valid  = !reset && !jump_flag && w_credit;
    assign w_req_fire   = w_req_valid && bus.imem_req_ready;
    assign w_inst_valid = (w_count != '0);
    assign w_pop        = w_inst_valid && bus.inst_ready && !jump_flag;
    // Responses are stale while the discard counter is non-zero.
    assign w_push       = bus.imem_rsp_valid && !jump_flag && (disc_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        disc_d     = disc_q;
        // No request fires during a redirect, so this covers both cases.
        out_d      = out_q + c_CNT_W'(w_req_fire) - c_CNT_W'(bus.imem_rsp_valid);
        if (jump_flag) begin
            fetch_pc_d = w_target;
            ret_pc_d   = w_target;
            disc_d     = out_d;
        end else begin
            if (w_req_fire) fetch_pc_d = fetch_pc_q + c_PC_STEP;
            if (w_push)     ret_pc_d   = ret_pc_q + c_PC_STEP;
            if (bus.imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENT_W)
    ) u_queue (
        .clk         (clk),
        .rst         (reset),
        .push_i      (w_push),
        .push_data_i ({ret_pc_q, bus.imem_rsp_data}),
        .pop_i       (w_pop),
        .flush_i     (jump_flag),
        .count_o     (w_count),
        .head_o      (w_head)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = w_inst_valid ? w_head[c_INST_W-1:0]       : '0;
    assign bus.inst_pc        = w_inst_valid ? w_head[c_ENT_W-1:c_INST_W] : '0;

    a_invariants : assert property (@(posedge clk) disable iff (reset)
        (disc_q <= out_q) && (({1'b0, out_q} + {1'b0, w_count}) <= c_DEPTH_EXT));

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A fixed-latency
//                in-order memory model answers requests; a monitor logs
//                accepted requests and delivered instructions, which each
//                scenario task compares against hand-derived values.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        jump_flag   = 1'b0;
    logic [31:0] jump_target = '0;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .jump_flag   (jump_flag),
        .jump_target (jump_target),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and monitor (runs on negedge) ----------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    int          acc_cyc[$];
    logic [31:0] dpc[$];
    logic [31:0] ddata[$];
    int          dcyc[$];
    int          cyc = 0;
    int          lat = 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mq.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{bus.imem_req_addr, cyc + lat});
                req_log.push_back(bus.imem_req_addr);
                acc_cyc.push_back(cyc);
            end
            if (bus.inst_valid && bus.inst_ready && !jump_flag) begin
                dpc.push_back(bus.inst_pc);
                ddata.push_back(bus.inst_data);
                dcyc.push_back(cyc);
            end
            if (mq.size() > 0 && mq[0].due == cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memf(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // ---------------- helpers (stimulus only) ------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        acc_cyc.delete();
        dpc.delete();
        ddata.delete();
        dcyc.delete();
    endtask

    // Leaves the bench 1 ns after a posedge with reset just released.
    task automatic apply_reset(input int l);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        jump_flag = 1'b0;
        lat       = l;
        step(2);
        clear_logs();
        reset = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        step(2);
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid);
        end
        n_checks++;
        if (bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst_zero: got data %h pc %h expected 0 0", bus.inst_data, bus.inst_pc);
        end
        n_checks++;
        if (bus.imem_req_addr !== RESET_PC) begin
            n_fail++; $display("FAIL reset_req_addr: got %h expected %h", bus.imem_req_addr, RESET_PC);
        end
        clear_logs();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL release_req_valid: got %b expected 1", bus.imem_req_valid);
        end
    endtask

    task automatic test_stream();
        bus.inst_ready = 1'b1;
        apply_reset(1);
        step(12);
        n_checks++;
        if (req_log.size() < 4 || dpc.size() < 8) begin
            n_fail++; $display("FAIL stream_sizes: got reqs %0d insts %0d expected >=4 >=8", req_log.size(), dpc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (req_log[i] !== 32'(4 * i)) begin
                    n_fail++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i));
                end
            end
            n_checks++;
            if (dcyc[0] - acc_cyc[0] !== 2) begin
                n_fail++; $display("FAIL stream_first_latency: got %0d expected 2", dcyc[0] - acc_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (dpc[i] !== 32'(4 * i) || ddata[i] !== memf(32'(4 * i))) begin
                    n_fail++; $display("FAIL stream_inst[%0d]: got pc %h data %h expected pc %h data %h",
                                       i, dpc[i], ddata[i], 32'(4 * i), memf(32'(4 * i)));
                end
            end
            n_checks++;
            if (dcyc[7] - dcyc[0] !== 7) begin
                n_fail++; $display("FAIL stream_throughput: got %0d cycles for 8 insts expected 7", dcyc[7] - dcyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.inst_ready = 1'b0;
        apply_reset(1);
        step(10);
        n_checks++;
        if (req_log.size() !== 4) begin
            n_fail++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size());
        end
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: got valid %b pc %h expected 1 00000000", bus.inst_valid, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        step(8);
        n_checks++;
        if (dpc.size() < 4 || req_log.size() < 5) begin
            n_fail++; $display("FAIL bp_drain_size: got insts %0d reqs %0d expected >=4 >=5", dpc.size(), req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dpc[i] !== 32'(4 * i) || ddata[i] !== memf(32'(4 * i))) begin
                    n_fail++; $display("FAIL bp_drain[%0d]: got pc %h data %h expected pc %h data %h",
                                       i, dpc[i], ddata[i], 32'(4 * i), memf(32'(4 * i)));
                end
            end
            n_checks++;
            if (req_log[4] !== 32'h10) begin
                n_fail++; $display("FAIL bp_resume_addr: got %h expected 00000010", req_log[4]);
            end
        end
    endtask

    task automatic test_redirect_stale();
        bus.inst_ready = 1'b1;
        apply_reset(3);
        step(2);
        jump_target = 32'h0000_0103;
        jump_flag   = 1'b1;
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL stale_req_during_jump: got %b expected 0", bus.imem_req_valid);
        end
        n_checks++;
        if (req_log.size() !== 2) begin
            n_fail++; $display("FAIL stale_inflight: got %0d expected 2", req_log.size());
        end
        step(1);
        jump_flag = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL stale_queue_empty: got %b expected 0", bus.inst_valid);
        end
        step(12);
        n_checks++;
        if (dpc.size() < 2 || req_log.size() < 3) begin
            n_fail++; $display("FAIL stale_sizes: got insts %0d reqs %0d expected >=2 >=3", dpc.size(), req_log.size());
        end else begin
            n_checks++;
            if (req_log[2] !== 32'h100) begin
                n_fail++; $display("FAIL stale_new_req: got %h expected 00000100", req_log[2]);
            end
            n_checks++;
            if (dpc[0] !== 32'h100 || ddata[0] !== memf(32'h100)) begin
                n_fail++; $display("FAIL stale_first_inst: got pc %h data %h expected pc 00000100 data %h",
                                   dpc[0], ddata[0], memf(32'h100));
            end
            n_checks++;
            if (dpc[1] !== 32'h104) begin
                n_fail++; $display("FAIL stale_second_inst: got %h expected 00000104", dpc[1]);
            end
        end
    endtask

    task automatic test_redirect_collide();
        int nb;
        bus.inst_ready = 1'b1;
        apply_reset(2);
        step(8);
        jump_target = 32'h0000_0200;
        jump_flag   = 1'b1;
        #1;
        n_checks++;
        if (bus.inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL collide_pop_pending: got %b expected 1", bus.inst_valid);
        end
        nb = dpc.size();
        step(1);
        jump_flag = 1'b0;
        step(10);
        n_checks++;
        if (nb < 1 || dpc.size() < nb + 2) begin
            n_fail++; $display("FAIL collide_sizes: got before %0d total %0d expected >=1 >=%0d", nb, dpc.size(), nb + 2);
        end else begin
            n_checks++;
            if (dpc[nb - 1] !== 32'(4 * (nb - 1))) begin
                n_fail++; $display("FAIL collide_pre_jump: got %h expected %h", dpc[nb - 1], 32'(4 * (nb - 1)));
            end
            n_checks++;
            if (dpc[nb] !== 32'h200 || ddata[nb] !== memf(32'h200)) begin
                n_fail++; $display("FAIL collide_first_target: got pc %h data %h expected pc 00000200 data %h",
                                   dpc[nb], ddata[nb], memf(32'h200));
            end
            n_checks++;
            if (dpc[nb + 1] !== 32'h204) begin
                n_fail++; $display("FAIL collide_second_target: got %h expected 00000204", dpc[nb + 1]);
            end
        end
    endtask

    task automatic test_wrap();
        int          nb;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0004;
        bus.inst_ready = 1'b1;
        apply_reset(1);
        step(6);
        jump_target = 32'hFFFF_FFFB;
        jump_flag   = 1'b1;
        #1;
        nb = dpc.size();
        step(1);
        jump_flag = 1'b0;
        step(10);
        n_checks++;
        if (dpc.size() < nb + 4) begin
            n_fail++; $display("FAIL wrap_size: got %0d expected >=%0d", dpc.size(), nb + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dpc[nb + i] !== exp_pc[i] || ddata[nb + i] !== memf(exp_pc[i])) begin
                    n_fail++; $display("FAIL wrap_inst[%0d]: got pc %h data %h expected pc %h data %h",
                                       i, dpc[nb + i], ddata[nb + i], exp_pc[i], memf(exp_pc[i]));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.inst_ready = 1'b1;
        apply_reset(1);
        step(6);
        #2;
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got inst_valid %b req_valid %b expected 1 1", bus.inst_valid, bus.imem_req_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate: got inst_valid %b req_valid %b expected 0 0", bus.inst_valid, bus.imem_req_valid);
        end
        n_checks++;
        if (bus.imem_req_addr !== RESET_PC) begin
            n_fail++; $display("FAIL areset_addr: got %h expected %h", bus.imem_req_addr, RESET_PC);
        end
        step(2);
        clear_logs();
        reset = 1'b0;
        step(6);
        n_checks++;
        if (req_log.size() < 1 || dpc.size() < 2) begin
            n_fail++; $display("FAIL areset_restart_size: got reqs %0d insts %0d expected >=1 >=2", req_log.size(), dpc.size());
        end else begin
            n_checks++;
            if (req_log[0] !== RESET_PC) begin
                n_fail++; $display("FAIL areset_first_req: got %h expected %h", req_log[0], RESET_PC);
            end
            n_checks++;
            if (dpc[0] !== RESET_PC || ddata[0] !== memf(RESET_PC) || dpc[1] !== RESET_PC + 32'h4) begin
                n_fail++; $display("FAIL areset_first_insts: got pc %h data %h next %h expected pc %h data %h next %h",
                                   dpc[0], ddata[0], dpc[1], RESET_PC, memf(RESET_PC), RESET_PC + 32'h4);
            end
        end
    endtask

    // ---------------- sequence ---------------------------------------------
    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collide();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that succeeds the current single-cycle PC register plus instruction-memory read. It issues pipelined requests over a valid/ready instruction-memory interface and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. Decoded instructions go to the decode stage through a valid/ready handshake. On a jump it flushes the queue and drops stale in-flight responses.

Parameters:
XLEN, 32, address/data width in bits.
RESET_PC, 32'h0000_0000, fetch address after reset.
DEPTH, 4, prefetch queue entries and max (outstanding + queued); power of 2, >=2.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
jump_flag  input  1  redirect request from jump_controller (single-cycle pulse)
jump_target  input  XLEN  redirect address; bits [1:0] ignored (treated as 00)
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_rsp_valid  input  1  response valid; in order, no backpressure, latency >=1
imem_rsp_data  input  32  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  decode consumes head
inst_data  output  32  head instruction; 0 when inst_valid=0
inst_pc  output  XLEN  head PC; 0 when inst_valid=0

Behaviour:
- One clock, clk; reset asynchronous active-high. While reset is high and after release: fetch_pc=RESET_PC, queue count=0, outstanding O=0, discard D=0; imem_req_valid=0 and inst_valid=0 during reset, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
- Credit rule: imem_req_valid = !jump_flag && (O + count < DEPTH), using registered O and count. This guarantees every response fits in the queue without backpressure.
- Request accept (valid&&ready): O+1, fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0).
- Response, no redirect this cycle: O-1. If D>0: D-1 and data dropped. Else push {pc_tag, data}.
- pc_tag comes from a return-PC register: set to the redirect target on redirect, RESET_PC on reset, and +4 per pushed entry.
- Latency: request accepted cycle N, response cycle N+k, inst_valid high at N+k+1. No bypass from imem_rsp to inst outputs.
- Pop when inst_valid && inst_ready. Push and pop may occur in the same cycle; count is unchanged.
- Redirect (jump_flag=1) has priority over everything:
  - Queue flushed, count=0.
  - Any pop this cycle is ignored.
  - Any response this cycle is dropped; O_next = O - rsp_valid.
  - D_next = O_next, so every remaining in-flight response is stale.
  - fetch_pc and return-PC = {jump_target[XLEN-1:2],2'b00}.
  - No request is issued this cycle.
- A redirect while D>0 is legal: D is simply overwritten with O_next.
- Back-to-back redirects are legal; the last one wins.
- Full throughput (1 inst/cycle) requires DEPTH >= memory latency + 2.
- Counters O, D and count are $clog2(DEPTH+1) bits wide. Invariant: D <= O; O + count <= DEPTH. An assertion fires on any violation.
- Reset mid-operation: all state clears immediately. Responses arriving after reset release for pre-reset requests are outside the contract; the memory side must be reset together.

Decomposition:
- define.vh gets: XLEN default, RESET_PC default, INST_BYTES=4.
- Sub-module fetch_queue: synchronous FIFO with DEPTH entries of (XLEN+32) bits and ports push, pop, flush, count, head.
- fetch_unit holds fetch_pc, return-PC, O/D counters, credit logic and redirect handling.

Test Plan:
1. Reset release, 1-cycle memory, inst_ready=1, DEPTH=4 -> requests at 0x0,0x4,0x8…; first inst_valid 2 cycles after first accept with inst_pc=0x0. Steady state is 1 inst/cycle with correct data.
2. inst_ready=0 held -> exactly 4 requests accepted, then imem_req_valid=0. count=4, no response lost. Releasing inst_ready drains in order 0x0..0xC.
3. Memory latency 3, two requests in flight, jump_flag with jump_target=0x103 -> both stale responses dropped. Next inst_pc=0x100; queue is empty in the cycle after the redirect.
4. Redirect in the same cycle as a response and as inst_ready pop -> response dropped, pop ignored, D = O-1. First delivered PC = target.
5. fetch_pc=0xFFFF_FFF8 via redirect -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Assert reset asynchronously mid-stream (between clock edges) -> inst_valid and imem_req_valid drop immediately. After release, fetch restarts at RESET_PC.
